pdh_iq_rotator: RTL and testbench
=================================

# pdh_iq_rotator

Parametrised, pipelined IQ rotation and averaging stage for the PDH error-signal path. It sits between the offset-corrected signed ADC samples and the downstream lock/readout logic. It extends the single-cycle rotator with several features: staged cos/sin coefficients that commit atomically on a sample boundary, saturating rather than truncating arithmetic, and a decimating power-of-two boxcar averager with PS-selectable window length.

## Interface
- DATA_W, 16, signed sample width of inputs and outputs
- COEF_W, 16, signed Q1.(COEF_W-1) coefficient width
- AVG_MAX_LOG2, 8, largest supported averaging window exponent
- clk  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- adc_a_i  in  DATA_W  signed I-path sample
- adc_b_i  in  DATA_W  signed Q-path sample
- in_valid_i  in  1  sample qualifier
- coef_i  in  COEF_W  coefficient write data
- coef_sel_i  in  1  0 = cos staging, 1 = sin staging
- coef_wr_i  in  1  single-cycle write pulse
- commit_i  in  1  single-cycle commit request
- avg_log2_i  in  4  averaging window exponent; values above AVG_MAX_LOG2 clamp to AVG_MAX_LOG2
- i_o, q_o  out  DATA_W  rotated, saturated samples
- out_valid_o  out  1  qualifies i_o/q_o
- i_avg_o, q_avg_o  out  DATA_W  window means
- avg_valid_o  out  1  one-cycle pulse per completed window
- commit_pending_o  out  1  commit requested but not yet applied
- cos_act_o, sin_act_o  out  COEF_W  active coefficients, for PS readback

## Operation
- Staging: on coef_wr_i, the register selected by coef_sel_i takes coef_i. Staged values never affect the datapath directly.
- Commit: commit_i sets the pending flag. On the first cycle with pending and in_valid_i both high, active cos/sin take the staged values and pending clears. The committed pair is the staged pair as registered before that edge.
  - The sample accepted on the swap cycle uses the old coefficients. The next accepted sample uses the new pair.
  - If commit_i arrives while pending is already set, there is no extra effect.
- Simultaneous coef_wr_i and swap on the same edge: the swap uses the old staged value, and the write lands in staging for a later commit.
- Rotation:
  - I = cos·a − sin·b
  - Q = sin·a + cos·b
  - Products are DATA_W+COEF_W bits wide; each sum is one bit wider.
  - Each sum is arithmetic-shifted right by COEF_W−1 (floor), then saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Averager:
  - Per channel, the accumulator is DATA_W+AVG_MAX_LOG2 bits wide. It also holds a sample counter.
  - After N = 2^k rotated samples, it outputs sum >>> k (floor), pulses avg_valid_o, and clears for the next window.
  - k = 0 means every sample is emitted.
- Window restart: the accumulator and counter clear, and the partial window is discarded, when either of these happens:
  - a coefficient swap occurs;
  - avg_log2_i differs from its value registered the previous cycle.
- Reset values:
  - all outputs 0, except cos_act_o = staged cos = 2^(COEF_W−1)−1 (0x7FFF) and sin_act_o = staged sin = 0;
  - pending = 0, counter = 0, accumulators = 0.

## Timing
- Stage 1 registers the four products and the valid bit. Stage 2 registers the sums after shift and saturate, together with out_valid_o.
- Latency from in_valid_i to out_valid_o is exactly 2 cycles. Throughput is one sample per cycle, and bubbles pass through.
- avg_valid_o asserts 1 cycle after the out_valid_o of the window's last sample. i_avg_o/q_avg_o hold until the next pulse.
- Commit latency is 1 cycle minimum: a commit at cycle t with in_valid_i high at t+1 swaps at the t+1 edge.
- rst_i asserted mid-pipeline flushes all valids; the first output after release needs a fresh sample plus 2 cycles.
- Swap and window completion on the same cycle: the completed window is emitted, and a new window starts empty.

## Test plan
- Identity after reset, with a = 1000 and b = −500 → i_o = 999, q_o = −500, out_valid_o exactly 2 cycles after in_valid_i.
- Saturation: stage and commit cos = sin = 0x7FFF, then apply a = b = 0x7FFF → i_o = 0, q_o = 0x7FFF; apply a = b = −32768 → q_o = −32768.
- Atomic commit:
  - stage cos = 0, sin = 0x7FFF, then pulse commit_i with in_valid_i low for 5 cycles → commit_pending_o stays high and cos_act_o stays 0x7FFF;
  - the next valid sample swaps, and the sample after it with a = 1000, b = 0 gives i_o = 0, q_o = 999.
- Averaging: with avg_log2_i = 2, identity coefficients and a = 4, 8, 12, 16 → a single avg_valid_o pulse with i_avg_o = 9. Each identity output is floored one lower, so 3 + 7 + 11 + 15 = 36 and 36 >> 2 = 9.
- Window restart: with avg_log2_i = 2, change it to 1 after two samples → the partial sum is discarded and the next avg_valid_o covers the following 2 samples only. A commit mid-window discards the window the same way.
- Reset mid-operation: assert rst_i while 2 samples are in flight and pending = 1 → out_valid_o never asserts for them, pending clears, and coefficients return to 0x7FFF/0.

Source files
------------

// File: rtl/pdh_iq_rotator.sv
// pdh_iq_rotator
// ---------------------------------------------------------------------------
// Pipelined IQ rotation and boxcar averaging stage for the PDH error path.
// Rotates the signed (a, b) sample pair by a committed cos/sin pair,
// saturates the result to DATA_W, and produces decimated window means over
// 2^k rotated samples.
//
// Ports
//   clk, rst_i                 clock, synchronous active-high reset
//   adc_a_i, adc_b_i           signed I/Q input samples
//   in_valid_i                 input sample qualifier
//   coef_i, coef_sel_i,        coefficient staging write (sel 0 = cos,
//   coef_wr_i                  sel 1 = sin)
//   commit_i                   request atomic staged -> active swap
//   avg_log2_i                 averaging window exponent k (clamped)
//   i_o, q_o, out_valid_o      rotated, saturated samples (2-cycle latency)
//   i_avg_o, q_avg_o,          window means, one-cycle pulse per window
//   avg_valid_o
//   commit_pending_o           commit requested but not yet applied
//   cos_act_o, sin_act_o       active coefficients for readback
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge where in_valid_i is high; out_valid_o and avg_valid_o qualify their
// data on the cycle they are high and are never stalled.
// ---------------------------------------------------------------------------
module pdh_iq_rotator #(
  parameter int DATA_W       = 16,
  parameter int COEF_W       = 16,
  parameter int AVG_MAX_LOG2 = 8
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic signed [DATA_W-1:0] adc_a_i,
  input  logic signed [DATA_W-1:0] adc_b_i,
  input  logic                     in_valid_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic                     coef_sel_i,
  input  logic                     coef_wr_i,
  input  logic                     commit_i,
  input  logic [3:0]               avg_log2_i,
  output logic signed [DATA_W-1:0] i_o,
  output logic signed [DATA_W-1:0] q_o,
  output logic                     out_valid_o,
  output logic signed [DATA_W-1:0] i_avg_o,
  output logic signed [DATA_W-1:0] q_avg_o,
  output logic                     avg_valid_o,
  output logic                     commit_pending_o,
  output logic signed [COEF_W-1:0] cos_act_o,
  output logic signed [COEF_W-1:0] sin_act_o
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int ACC_W  = DATA_W + AVG_MAX_LOG2;
  localparam int CNT_W  = AVG_MAX_LOG2 + 1;

  // Largest positive Q1.(COEF_W-1) value, i.e. "almost 1.0".
  localparam logic signed [COEF_W-1:0] COEF_ONE = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]  SAT_MAX  =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0]  SAT_MIN  =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // ---------------- coefficient staging / commit ----------------
  logic signed [COEF_W-1:0] r_cos_stg;
  logic signed [COEF_W-1:0] r_sin_stg;
  logic                     w_swap;

  // The swap only happens on an accepted sample so the coefficient change
  // lines up with a sample boundary.
  assign w_swap = commit_pending_o & in_valid_i;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_cos_stg        <= COEF_ONE;
      r_sin_stg        <= '0;
      cos_act_o        <= COEF_ONE;
      sin_act_o        <= '0;
      commit_pending_o <= 1'b0;
    end else begin
      if (commit_i) commit_pending_o <= 1'b1;
      // Swap wins over a same-cycle commit: the request is already pending.
      if (w_swap) begin
        cos_act_o        <= r_cos_stg;
        sin_act_o        <= r_sin_stg;
        commit_pending_o <= 1'b0;
      end
      // A write on the swap edge lands in staging for a later commit; the
      // swap above reads the pre-edge staged value.
      if (coef_wr_i) begin
        if (coef_sel_i) r_sin_stg <= coef_i;
        else            r_cos_stg <= coef_i;
      end
    end
  end

  // ---------------- stage 1: products ----------------
  logic signed [PROD_W-1:0] r_p_ca, r_p_sb, r_p_sa, r_p_cb;
  logic                     r_v1;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_v1   <= 1'b0;
      r_p_ca <= '0;
      r_p_sb <= '0;
      r_p_sa <= '0;
      r_p_cb <= '0;
    end else begin
      r_v1   <= in_valid_i;
      r_p_ca <= PROD_W'(cos_act_o) * PROD_W'(adc_a_i);
      r_p_sb <= PROD_W'(sin_act_o) * PROD_W'(adc_b_i);
      r_p_sa <= PROD_W'(sin_act_o) * PROD_W'(adc_a_i);
      r_p_cb <= PROD_W'(cos_act_o) * PROD_W'(adc_b_i);
    end
  end

  // ---------------- stage 2: sum, shift, saturate ----------------
  logic signed [SUM_W-1:0] w_sum_i, w_sum_q, w_shr_i, w_shr_q;

  assign w_sum_i = SUM_W'(r_p_ca) - SUM_W'(r_p_sb);
  assign w_sum_q = SUM_W'(r_p_sa) + SUM_W'(r_p_cb);
  assign w_shr_i = w_sum_i >>> (COEF_W - 1);
  assign w_shr_q = w_sum_q >>> (COEF_W - 1);

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] x);
    if (x > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return x[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      i_o         <= '0;
      q_o         <= '0;
    end else begin
      out_valid_o <= r_v1;
      i_o         <= sat(w_shr_i);
      q_o         <= sat(w_shr_q);
    end
  end

  // ---------------- boxcar averager ----------------
  logic [3:0]              r_avg_log2;
  logic [3:0]              w_k;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_n_m1;
  logic signed [ACC_W-1:0] r_acc_i, r_acc_q;
  logic signed [ACC_W-1:0] w_acc_i_next, w_acc_q_next;
  logic signed [ACC_W-1:0] w_mean_i, w_mean_q;
  logic                    w_last;
  logic                    w_restart;

  // Window length follows the exponent registered last cycle, so a window
  // completing on the same cycle the exponent changes uses its own length.
  assign w_k          = (r_avg_log2 > 4'(AVG_MAX_LOG2)) ? 4'(AVG_MAX_LOG2) : r_avg_log2;
  assign w_n_m1       = (CNT_W'(1) << w_k) - CNT_W'(1);
  assign w_last       = out_valid_o && (r_cnt == w_n_m1);
  assign w_restart    = w_swap || (avg_log2_i != r_avg_log2);
  assign w_acc_i_next = r_acc_i + ACC_W'(i_o);
  assign w_acc_q_next = r_acc_q + ACC_W'(q_o);
  assign w_mean_i     = w_acc_i_next >>> w_k;
  assign w_mean_q     = w_acc_q_next >>> w_k;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_avg_log2  <= '0;
      r_cnt       <= '0;
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      i_avg_o     <= '0;
      q_avg_o     <= '0;
      avg_valid_o <= 1'b0;
    end else begin
      r_avg_log2  <= avg_log2_i;
      avg_valid_o <= 1'b0;
      // A completed window is always emitted, even if a restart coincides.
      if (w_last) begin
        i_avg_o     <= DATA_W'(w_mean_i);
        q_avg_o     <= DATA_W'(w_mean_q);
        avg_valid_o <= 1'b1;
      end
      if (w_restart || w_last) begin
        r_cnt   <= '0;
        r_acc_i <= '0;
        r_acc_q <= '0;
      end else if (out_valid_o) begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_acc_i <= w_acc_i_next;
        r_acc_q <= w_acc_q_next;
      end
    end
  end

endmodule

// File: tb/tb_pdh_iq_rotator.sv
// Directed testbench for pdh_iq_rotator: reset state, identity rotation and
// latency, saturation, atomic commit, averaging, window restart, clamped
// window exponent and mid-pipeline reset.
module tb_pdh_iq_rotator;

  logic               clk = 1'b0;
  logic               rst_i;
  logic signed [15:0] adc_a_i, adc_b_i;
  logic               in_valid_i;
  logic signed [15:0] coef_i;
  logic               coef_sel_i, coef_wr_i, commit_i;
  logic [3:0]         avg_log2_i;
  logic signed [15:0] i_o, q_o, i_avg_o, q_avg_o;
  logic               out_valid_o, avg_valid_o, commit_pending_o;
  logic signed [15:0] cos_act_o, sin_act_o;

  pdh_iq_rotator #(.DATA_W(16), .COEF_W(16), .AVG_MAX_LOG2(8)) dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .adc_a_i          (adc_a_i),
    .adc_b_i          (adc_b_i),
    .in_valid_i       (in_valid_i),
    .coef_i           (coef_i),
    .coef_sel_i       (coef_sel_i),
    .coef_wr_i        (coef_wr_i),
    .commit_i         (commit_i),
    .avg_log2_i       (avg_log2_i),
    .i_o              (i_o),
    .q_o              (q_o),
    .out_valid_o      (out_valid_o),
    .i_avg_o          (i_avg_o),
    .q_avg_o          (q_avg_o),
    .avg_valid_o      (avg_valid_o),
    .commit_pending_o (commit_pending_o),
    .cos_act_o        (cos_act_o),
    .sin_act_o        (sin_act_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int avg_pulses = 0;
  logic signed [15:0] last_i_avg = '0;
  logic signed [15:0] last_q_avg = '0;
  logic out_seen;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge and sample outputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    if (avg_valid_o) begin
      avg_pulses++;
      last_i_avg = i_avg_o;
      last_q_avg = q_avg_o;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int a, input int b);
    adc_a_i    = 16'(a);
    adc_b_i    = 16'(b);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic write_coef(input logic sel, input int val);
    coef_sel_i = sel;
    coef_i     = 16'(val);
    coef_wr_i  = 1'b1;
    tick();
    coef_wr_i  = 1'b0;
  endtask

  task automatic commit();
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_i = 1'b1; adc_a_i = '0; adc_b_i = '0; in_valid_i = 1'b0;
    coef_i = '0; coef_sel_i = 1'b0; coef_wr_i = 1'b0; commit_i = 1'b0;
    avg_log2_i = 4'd0;
    idle(3);
    rst_i = 1'b0;
    tick();

    // Reset state
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_i_o", i_o, 0);
    chk("rst_avg_valid", avg_valid_o, 0);
    chk("rst_i_avg", i_avg_o, 0);
    chk("rst_pending", commit_pending_o, 0);
    chk("rst_cos_act", cos_act_o, 32767);
    chk("rst_sin_act", sin_act_o, 0);

    // Identity rotation and 2-cycle latency; k = 0 emits every sample
    send(1000, -500);
    chk("lat_cycle1_valid", out_valid_o, 0);
    tick();
    chk("lat_cycle2_valid", out_valid_o, 1);
    chk("ident_i", i_o, 999);
    chk("ident_q", q_o, -500);
    chk("ident_avg_not_yet", avg_valid_o, 0);
    tick();
    chk("lat_bubble_valid", out_valid_o, 0);
    chk("k0_avg_valid", avg_valid_o, 1);
    chk("k0_i_avg", i_avg_o, 999);
    chk("k0_q_avg", q_avg_o, -500);

    // Saturation with cos = sin = 0x7FFF
    write_coef(1'b1, 32767);
    commit();
    send(0, 0);
    chk("sat_commit_sin", sin_act_o, 32767);
    chk("sat_commit_pending", commit_pending_o, 0);
    idle(2);
    send(32767, 32767);
    tick();
    chk("sat_pos_i", i_o, 0);
    chk("sat_pos_q", q_o, 32767);
    send(-32768, -32768);
    tick();
    chk("sat_neg_i", i_o, 0);
    chk("sat_neg_q", q_o, -32768);

    // Atomic commit: no swap while in_valid_i stays low
    write_coef(1'b0, 0);
    write_coef(1'b1, 32767);
    commit();
    idle(5);
    chk("atomic_pending_held", commit_pending_o, 1);
    chk("atomic_cos_held", cos_act_o, 32767);
    send(0, 0);
    chk("atomic_pending_clr", commit_pending_o, 0);
    chk("atomic_cos_new", cos_act_o, 0);
    idle(2);
    send(1000, 0);
    tick();
    chk("atomic_i", i_o, 0);
    chk("atomic_q", q_o, 999);

    // Restore identity coefficients
    write_coef(1'b0, 32767);
    write_coef(1'b1, 0);
    commit();
    send(0, 0);
    idle(3);

    // Averaging, k = 2: 3 + 7 + 11 + 15 = 36, 36 >> 2 = 9
    avg_log2_i = 4'd2;
    idle(2);
    avg_pulses = 0;
    send(4, 0); send(8, 0); send(12, 0); send(16, 0);
    idle(4);
    chk("avg4_pulses", avg_pulses, 1);
    chk("avg4_i", last_i_avg, 9);
    chk("avg4_q", last_q_avg, 0);

    // Window restart on exponent change: partial (3, 7) discarded
    avg_pulses = 0;
    send(4, 0); send(8, 0);
    idle(3);
    avg_log2_i = 4'd1;
    idle(2);
    send(100, 0); send(200, 0);
    idle(4);
    chk("restart_k_pulses", avg_pulses, 1);
    chk("restart_k_i", last_i_avg, 149);

    // Window restart on commit: new window 19+39+59+79 = 196, >> 2 = 49
    avg_log2_i = 4'd2;
    idle(2);
    avg_pulses = 0;
    send(4, 0); send(8, 0);
    idle(3);
    write_coef(1'b0, 32767);
    write_coef(1'b1, 0);
    commit();
    send(20, 0); send(40, 0); send(60, 0); send(80, 0);
    idle(4);
    chk("restart_commit_pulses", avg_pulses, 1);
    chk("restart_commit_i", last_i_avg, 49);

    // Exponent above the maximum clamps to 8 (256-sample window)
    avg_log2_i = 4'd15;
    idle(2);
    avg_pulses = 0;
    repeat (255) send(4, 0);
    idle(4);
    chk("clamp_no_early_pulse", avg_pulses, 0);
    send(4, 0);
    idle(4);
    chk("clamp_pulses", avg_pulses, 1);
    chk("clamp_i", last_i_avg, 3);

    // Reset mid-pipeline with a commit pending
    avg_log2_i = 4'd0;
    idle(2);
    write_coef(1'b0, 0);
    write_coef(1'b1, 32767);
    adc_a_i = 16'sd1000; adc_b_i = 16'sd0;
    in_valid_i = 1'b1; commit_i = 1'b1;
    tick();
    commit_i = 1'b0; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; in_valid_i = 1'b0;
    out_seen = 1'b0;
    repeat (4) begin
      if (out_valid_o) out_seen = 1'b1;
      tick();
    end
    chk("midrst_no_output", out_seen, 0);
    chk("midrst_pending", commit_pending_o, 0);
    chk("midrst_cos", cos_act_o, 32767);
    chk("midrst_sin", sin_act_o, 0);
    // Staged registers were reset too: committing now keeps identity
    commit();
    send(1000, 0);
    tick();
    chk("midrst_first_out_valid", out_valid_o, 1);
    send(1000, 0);
    tick();
    chk("midrst_staged_i", i_o, 999);
    chk("midrst_staged_q", q_o, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
